// File: rtl/match_controller.sv
// -----------------------------------------------------------------------------
// match_controller
//
// Match sequencer for the pong game. It runs the match through five states:
// idle, serve delay, rally, point pause and game over. It keeps both scores,
// picks the serve direction, and drives ball motion (ball_run_o) and ball
// re-centring (ball_load_o). All delays are counted in video frames using
// frame_tick_i.
//
// Parameters:
//   WIN_SCORE    points needed to win (1 <= WIN_SCORE < 2**SCORE_W)
//   SCORE_W      width of each score counter
//   SERVE_FRAMES frame ticks spent in SERVE before the ball moves (>= 1)
//   POINT_FRAMES frame ticks of pause after a point (>= 1)
//
// Ports:
//   clk_i          clock; all logic runs on the rising edge
//   rst_i          synchronous active-low reset
//   frame_tick_i   one-cycle pulse per video frame
//   start_i        start key level; only its rising edge is used
//   player_miss_i  one-cycle pulse: ball passed the player paddle
//   pc_miss_i      one-cycle pulse: ball passed the PC paddle
//   ball_run_o     ball motion enable, high exactly while in PLAY
//   ball_load_o    one-cycle pulse on the first SERVE cycle
//                  (re-centres the ball and loads serve_dir_o)
//   serve_dir_o    serve direction, 0 = toward player, 1 = toward PC
//   player_score_o player score
//   pc_score_o     PC score
//   winner_o       match winner, valid in OVER (0 = player, 1 = PC)
//   state_o        current state: IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
//
// Every output comes straight from a register. Each register is loaded from
// the next-state values, so all outputs change on the same edge as state_o.
// -----------------------------------------------------------------------------
module match_controller #(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_tick_i,
  input  logic               start_i,
  input  logic               player_miss_i,
  input  logic               pc_miss_i,
  output logic               ball_run_o,
  output logic               ball_load_o,
  output logic               serve_dir_o,
  output logic [SCORE_W-1:0] player_score_o,
  output logic [SCORE_W-1:0] pc_score_o,
  output logic               winner_o,
  output logic [2:0]         state_o
);

  localparam int FCNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int FCNT_W   = $clog2(FCNT_MAX + 1);

  localparam logic [FCNT_W-1:0]  SERVE_LAST = FCNT_W'(SERVE_FRAMES);
  localparam logic [FCNT_W-1:0]  POINT_LAST = FCNT_W'(POINT_FRAMES);
  localparam logic [FCNT_W-1:0]  FCNT_ONE   = FCNT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Registered state and outputs
  state_t             r_state;
  logic [FCNT_W-1:0]  r_fcnt;
  logic               r_start_q;
  logic               r_ball_run;
  logic               r_ball_load;
  logic               r_serve_dir;
  logic [SCORE_W-1:0] r_player_score;
  logic [SCORE_W-1:0] r_pc_score;
  logic               r_winner;

  // Next-state values
  state_t             w_state_next;
  logic [FCNT_W-1:0]  w_fcnt_next;
  logic               w_ball_load_next;
  logic               w_serve_dir_next;
  logic [SCORE_W-1:0] w_player_score_next;
  logic [SCORE_W-1:0] w_pc_score_next;
  logic               w_winner_next;

  logic               w_start_rise;
  logic [FCNT_W-1:0]  w_fcnt_inc;
  logic [SCORE_W-1:0] w_player_inc;
  logic [SCORE_W-1:0] w_pc_inc;

  // r_start_q resets to 1, so a key held through reset is not seen as an edge.
  assign w_start_rise = start_i & ~r_start_q;
  assign w_fcnt_inc   = r_fcnt + FCNT_ONE;
  assign w_player_inc = r_player_score + SCORE_ONE;
  assign w_pc_inc     = r_pc_score + SCORE_ONE;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next        = r_state;
    w_fcnt_next         = r_fcnt;
    w_ball_load_next    = 1'b0;
    w_serve_dir_next    = r_serve_dir;
    w_player_score_next = r_player_score;
    w_pc_score_next     = r_pc_score;
    w_winner_next       = r_winner;

    case (r_state)
      ST_IDLE, ST_OVER: begin
        // In OVER the scores and winner hold until a new match starts.
        if (w_start_rise) begin
          w_state_next        = ST_SERVE;
          w_ball_load_next    = 1'b1;
          w_serve_dir_next    = 1'b1;
          w_player_score_next = '0;
          w_pc_score_next     = '0;
          w_winner_next       = 1'b0;
        end
      end

      ST_SERVE: begin
        if (frame_tick_i) begin
          w_fcnt_next = w_fcnt_inc;
          if (w_fcnt_inc == SERVE_LAST) begin
            w_state_next = ST_PLAY;
          end
        end
      end

      ST_PLAY: begin
        if (player_miss_i && pc_miss_i) begin
          // Nobody scores: replay the serve in the same direction.
          w_state_next     = ST_SERVE;
          w_ball_load_next = 1'b1;
        end else if (player_miss_i) begin
          w_pc_score_next  = w_pc_inc;
          w_serve_dir_next = 1'b0;
          if (w_pc_inc == SCORE_WIN) begin
            w_state_next  = ST_OVER;
            w_winner_next = 1'b1;
          end else begin
            w_state_next = ST_POINT;
          end
        end else if (pc_miss_i) begin
          w_player_score_next = w_player_inc;
          w_serve_dir_next    = 1'b1;
          if (w_player_inc == SCORE_WIN) begin
            w_state_next  = ST_OVER;
            w_winner_next = 1'b0;
          end else begin
            w_state_next = ST_POINT;
          end
        end
      end

      ST_POINT: begin
        if (frame_tick_i) begin
          w_fcnt_next = w_fcnt_inc;
          if (w_fcnt_inc == POINT_LAST) begin
            w_state_next     = ST_SERVE;
            w_ball_load_next = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // The frame counter restarts on every state change. A tick in the same
    // cycle as the change is therefore never counted in the new state.
    if (w_state_next != r_state) begin
      w_fcnt_next = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state        <= ST_IDLE;
      r_fcnt         <= '0;
      r_start_q      <= 1'b1;
      r_ball_run     <= 1'b0;
      r_ball_load    <= 1'b0;
      r_serve_dir    <= 1'b1;
      r_player_score <= '0;
      r_pc_score     <= '0;
      r_winner       <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_fcnt         <= w_fcnt_next;
      r_start_q      <= start_i;
      r_ball_run     <= (w_state_next == ST_PLAY);
      r_ball_load    <= w_ball_load_next;
      r_serve_dir    <= w_serve_dir_next;
      r_player_score <= w_player_score_next;
      r_pc_score     <= w_pc_score_next;
      r_winner       <= w_winner_next;
    end
  end

  assign ball_run_o     = r_ball_run;
  assign ball_load_o    = r_ball_load;
  assign serve_dir_o    = r_serve_dir;
  assign player_score_o = r_player_score;
  assign pc_score_o     = r_pc_score;
  assign winner_o       = r_winner;
  assign state_o        = r_state;

endmodule

// File: tb/tb_match_controller.sv
// -----------------------------------------------------------------------------
// tb_match_controller
//
// Directed bench for match_controller, built with WIN_SCORE=2, SERVE_FRAMES=3
// and POINT_FRAMES=2. Inputs change 1 ns after a rising edge. Outputs are
// checked 1 ns after the next rising edge, so every check sees the registered
// result of that edge. Expected values are written out by hand for each step.
// -----------------------------------------------------------------------------
module tb_match_controller;

  localparam int WIN_SCORE    = 2;
  localparam int SCORE_W      = 4;
  localparam int SERVE_FRAMES = 3;
  localparam int POINT_FRAMES = 2;

  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_POINT = 3;
  localparam int S_OVER  = 4;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               frame_tick = 1'b0;
  logic               start = 1'b0;
  logic               player_miss = 1'b0;
  logic               pc_miss = 1'b0;
  logic               ball_run;
  logic               ball_load;
  logic               serve_dir;
  logic [SCORE_W-1:0] player_score;
  logic [SCORE_W-1:0] pc_score;
  logic               winner;
  logic [2:0]         state;

  match_controller #(
    .WIN_SCORE   (WIN_SCORE),
    .SCORE_W     (SCORE_W),
    .SERVE_FRAMES(SERVE_FRAMES),
    .POINT_FRAMES(POINT_FRAMES)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .frame_tick_i  (frame_tick),
    .start_i       (start),
    .player_miss_i (player_miss),
    .pc_miss_i     (pc_miss),
    .ball_run_o    (ball_run),
    .ball_load_o   (ball_load),
    .serve_dir_o   (serve_dir),
    .player_score_o(player_score),
    .pc_score_o    (pc_score),
    .winner_o      (winner),
    .state_o       (state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Checks every output against one expected vector.
  task automatic check_outs(input string tag, input int st, input int run, input int load,
                            input int dir, input int ps, input int pcs, input int win);
    check({tag, ".state"},     32'(state),        32'(st));
    check({tag, ".ball_run"},  32'(ball_run),     32'(run));
    check({tag, ".ball_load"}, 32'(ball_load),    32'(load));
    check({tag, ".serve_dir"}, 32'(serve_dir),    32'(dir));
    check({tag, ".player"},    32'(player_score), 32'(ps));
    check({tag, ".pc"},        32'(pc_score),     32'(pcs));
    check({tag, ".winner"},    32'(winner),       32'(win));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Nine quiet cycles, then a one-cycle frame tick (a tick every 10 cycles).
  task automatic tick();
    idle(9);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Start key released for one cycle, then pressed. An optional frame tick
  // lands in the same cycle as the press.
  task automatic start_edge(input logic with_tick);
    start = 1'b0;
    step();
    start      = 1'b1;
    frame_tick = with_tick;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic pulse_miss(input logic pm, input logic cm);
    player_miss = pm;
    pc_miss     = cm;
    step();
    player_miss = 1'b0;
    pc_miss     = 1'b0;
  endtask

  // Expects SERVE after ticks 1 and 2, and PLAY with the ball running
  // right after tick 3.
  task automatic serve_to_play(input string tag);
    tick();
    check({tag, ".t1"}, 32'(state), 32'(S_SERVE));
    tick();
    check({tag, ".t2"}, 32'(state), 32'(S_SERVE));
    check({tag, ".t2_run"}, 32'(ball_run), 32'd0);
    tick();
    check({tag, ".t3"}, 32'(state), 32'(S_PLAY));
    check({tag, ".t3_run"}, 32'(ball_run), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset with the start key held down.
    rst_n = 1'b0;
    start = 1'b1;
    idle(2);
    check_outs("reset", S_IDLE, 0, 0, 1, 0, 0, 0);

    // Releasing reset with the key still held must not start a match.
    rst_n = 1'b1;
    idle(3);
    check_outs("held_start", S_IDLE, 0, 0, 1, 0, 0, 0);

    // Real start edge: SERVE one cycle after the press, with a load pulse.
    start_edge(1'b0);
    check_outs("start", S_SERVE, 0, 1, 1, 0, 0, 0);
    step();
    check_outs("start_load_done", S_SERVE, 0, 0, 1, 0, 0, 0);

    // Misses and start edges during SERVE are ignored.
    pulse_miss(1'b1, 1'b0);
    check_outs("serve_miss", S_SERVE, 0, 0, 1, 0, 0, 0);
    start_edge(1'b0);
    check_outs("serve_start", S_SERVE, 0, 0, 1, 0, 0, 0);

    serve_to_play("serve1");

    // A start edge in PLAY is ignored.
    start_edge(1'b0);
    check_outs("play_start", S_PLAY, 1, 0, 1, 0, 0, 0);

    // Player misses: the PC scores, the serve goes toward the player, POINT.
    pulse_miss(1'b1, 1'b0);
    check_outs("pt_player_miss", S_POINT, 0, 0, 0, 0, 1, 0);

    // Misses during POINT are ignored. Then POINT_FRAMES ticks lead to SERVE.
    pulse_miss(1'b0, 1'b1);
    check_outs("point_miss", S_POINT, 0, 0, 0, 0, 1, 0);
    tick();
    check_outs("point_t1", S_POINT, 0, 0, 0, 0, 1, 0);
    tick();
    check_outs("point_t2", S_SERVE, 0, 1, 0, 0, 1, 0);
    step();
    check_outs("point_load_done", S_SERVE, 0, 0, 0, 0, 1, 0);

    // Both miss in the same cycle: replay with no score change and dir kept.
    serve_to_play("serve2");
    pulse_miss(1'b1, 1'b1);
    check_outs("both_miss", S_SERVE, 0, 1, 0, 0, 1, 0);
    step();
    check("both_miss_load_done", 32'(ball_load), 32'd0);

    // The player reaches WIN_SCORE through two PC misses.
    serve_to_play("serve3");
    pulse_miss(1'b0, 1'b1);
    check_outs("pc_miss1", S_POINT, 0, 0, 1, 1, 1, 0);
    tick();
    tick();
    check("pc_miss1_serve", 32'(state), 32'(S_SERVE));
    serve_to_play("serve4");
    pulse_miss(1'b0, 1'b1);
    check_outs("player_wins", S_OVER, 0, 0, 1, 2, 1, 0);

    // Misses in OVER are ignored, and the score holds across ticks.
    pulse_miss(1'b1, 1'b0);
    check_outs("over_miss", S_OVER, 0, 0, 1, 2, 1, 0);
    tick();
    check_outs("over_tick", S_OVER, 0, 0, 1, 2, 1, 0);

    // Restart from OVER. A tick in the same cycle as the press is not counted.
    start_edge(1'b1);
    check_outs("restart1", S_SERVE, 0, 1, 1, 0, 0, 0);
    serve_to_play("serve5");

    // The PC reaches WIN_SCORE, so the winner flag must read 1.
    pulse_miss(1'b1, 1'b0);
    check_outs("pc_pt1", S_POINT, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    serve_to_play("serve6");
    pulse_miss(1'b1, 1'b0);
    check_outs("pc_wins", S_OVER, 0, 0, 0, 0, 2, 1);

    // A new match clears the winner and resets the serve direction.
    start_edge(1'b0);
    check_outs("restart2", S_SERVE, 0, 1, 1, 0, 0, 0);

    // Reset during a rally, with a non-zero score and serve_dir = 0.
    serve_to_play("serve7");
    pulse_miss(1'b1, 1'b0);
    tick();
    tick();
    serve_to_play("serve8");
    check_outs("pre_reset", S_PLAY, 1, 0, 0, 0, 1, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_outs("mid_rally_reset", S_IDLE, 0, 0, 1, 0, 0, 0);

    // The key is still held, so nothing starts after reset.
    idle(2);
    check_outs("post_reset_hold", S_IDLE, 0, 0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
